// File: rtl/vram_access_arbiter.sv
// Arbitrates the single-port GPU VRAM between buffered CPU writes and GPU fetch reads.
// GPU reads win normally; vblank and a starvation counter let the write FIFO drain.
module vram_access_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst_B,
  input  logic                         vblank,
  input  logic                         cpu_wr_valid,
  input  logic [ADDR_W-1:0]            cpu_wr_addr,
  input  logic [DATA_W-1:0]            cpu_wr_data,
  output logic                         fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  input  logic                         overflow_clr,
  input  logic                         gpu_rd_req,
  input  logic [ADDR_W-1:0]            gpu_rd_addr,
  output logic                         gpu_rd_ready,
  output logic                         gpu_rd_valid,
  output logic [DATA_W-1:0]            gpu_rd_data,
  output logic [ADDR_W-1:0]            vram_addr,
  output logic [DATA_W-1:0]            vram_wdata,
  output logic                         vram_we,
  input  logic [DATA_W-1:0]            vram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    G_IDLE,
    G_FORCE_WR,
    G_VBL_WR,
    G_GPU_RD,
    G_IDLE_WR
  } grant_t;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic              rd_vld_p1;

  grant_t grant;
  logic   fifo_empty;
  logic   wr_grant;
  logic   rd_grant;
  logic   push;
  logic   pop;
  logic   drop;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);
  assign fifo_level = level;

  // Fixed-priority grant, evaluated every cycle
  always_comb begin
    grant = G_IDLE;
    if (!fifo_empty && starve_cnt == CNT_MAX) grant = G_FORCE_WR;
    else if (vblank && !fifo_empty)           grant = G_VBL_WR;
    else if (gpu_rd_req)                      grant = G_GPU_RD;
    else if (!fifo_empty)                     grant = G_IDLE_WR;
  end

  assign wr_grant = (grant == G_FORCE_WR) || (grant == G_VBL_WR) || (grant == G_IDLE_WR);
  assign rd_grant = (grant == G_GPU_RD);
  assign pop      = wr_grant;
  assign push     = cpu_wr_valid && (!fifo_full || pop);
  assign drop     = cpu_wr_valid && fifo_full && !pop;

  // RAM port drive; address and write data hold their last values when idle
  always_comb begin
    vram_we      = wr_grant;
    gpu_rd_ready = rd_grant;
    vram_addr    = addr_hold;
    vram_wdata   = wdata_hold;
    if (wr_grant) begin
      vram_addr  = fifo_addr[head];
      vram_wdata = fifo_data[head];
    end else if (rd_grant) begin
      vram_addr  = gpu_rd_addr;
    end
  end

  assign gpu_rd_valid = rd_vld_p1;
  assign gpu_rd_data  = vram_rdata;

  // Write buffer storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= cpu_wr_addr;
      fifo_data[tail] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      head       <= '0;
      tail       <= '0;
      level      <= '0;
      starve_cnt <= '0;
      overflow   <= 1'b0;
      rd_vld_p1  <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      if (fifo_empty || wr_grant)  starve_cnt <= '0;
      else if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);

      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;

      // Read data arrives from the synchronous RAM one cycle after the grant
      rd_vld_p1  <= rd_grant;
      addr_hold  <= vram_addr;
      wdata_hold <= vram_wdata;
    end
  end

endmodule

// File: doc/vram_access_arbiter.md
Name: vram_access_arbiter

Overview:
- Shares the single-port GPU VRAM (0x3700–0x3FFF window, 0x900 bytes, 12-bit offset) between two requesters.
  - CPU writes, already synchronized into the GPU clock domain.
  - GPU fetch-pipeline reads.
- CPU writes are buffered in a small FIFO so the 1 MHz bus never stalls.
- GPU reads normally win; a starvation counter guarantees that buffered writes drain.
- During vblank, CPU writes take priority.

Parameters:
- ADDR_W, 12, VRAM offset width.
- DATA_W, 8, data width.
- FIFO_DEPTH, 4, CPU write buffer entries; must be a power of 2, ≥2.
- STARVE_LIMIT, 8, maximum consecutive cycles a non-empty FIFO may go ungranted.

Ports:
- clk  in  1  GPU clock, 12.5875 MHz.
- rst_B  in  1  asynchronous active-low reset.
- vblank  in  1  high during vertical blanking.
- cpu_wr_valid  in  1  single-cycle write strobe, already synchronized.
- cpu_wr_addr  in  ADDR_W  write offset into VRAM.
- cpu_wr_data  in  DATA_W  write data.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_level  out  log2(FIFO_DEPTH)+1  number of entries held.
- overflow  out  1  sticky: a write was dropped.
- overflow_clr  in  1  clears overflow.
- gpu_rd_req  in  1  GPU read request.
- gpu_rd_addr  in  ADDR_W  read offset.
- gpu_rd_ready  out  1  read accepted this cycle.
- gpu_rd_valid  out  1  read data valid.
- gpu_rd_data  out  DATA_W  read data.
- vram_addr  out  ADDR_W  RAM address.
- vram_wdata  out  DATA_W  RAM write data.
- vram_we  out  1  RAM write enable.
- vram_rdata  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after the address.

Behaviour:
- Reset (rst_B low, asynchronous):
  - FIFO empty; starvation counter = 0; overflow = 0; gpu_rd_valid = 0.
  - vram_we = 0, vram_addr = 0, vram_wdata = 0.
  - fifo_full = 0, fifo_level = 0.
  - Reset mid-operation discards all buffered writes. The pending read is lost: no gpu_rd_valid after reset.
- Grant, decided combinationally each cycle in priority order:
  1. FORCE_WR: FIFO non-empty and starve_cnt == STARVE_LIMIT.
  2. VBL_WR: vblank and FIFO non-empty.
  3. GPU_RD: gpu_rd_req.
  4. IDLE_WR: FIFO non-empty.
  5. IDLE: otherwise.
- Any write grant:
  - vram_we = 1, vram_addr/vram_wdata = FIFO head.
  - Pops the FIFO at the clock edge.
- GPU_RD grant:
  - gpu_rd_ready = 1, vram_addr = gpu_rd_addr, vram_we = 0.
  - Next cycle: gpu_rd_valid = 1 (registered), gpu_rd_data = vram_rdata.
  - gpu_rd_ready = gpu_rd_req unless a write grant is active; a refused request must be held by the GPU.
- IDLE: vram_we = 0; vram_addr holds its last value.
- Starvation counter:
  - Cleared when the FIFO is empty or a write is granted.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - A FIFO that stays non-empty under continuous GPU requests is therefore written at least once every STARVE_LIMIT+1 cycles.
- FIFO:
  - Push on cpu_wr_valid when not full, or when full and a pop occurs the same cycle.
  - No bypass: a write pushed into an empty FIFO reaches the RAM no earlier than the next cycle.
  - fifo_level and fifo_full reflect registered state.
  - Head/tail pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - cpu_wr_valid while full and not popping drops the write and sets overflow.
  - overflow_clr clears it; if set and clear coincide, set wins.
- Ordering and hazards:
  - Writes reach the RAM in arrival order.
  - No read-after-write forwarding: a GPU read returns RAM contents even if a newer write to that address is still buffered. Software writes VRAM during vblank, when the FIFO drains first.

Test Plan:
- Reset mid-stream with 3 entries queued -> fifo_level = 0, vram_we = 0, gpu_rd_valid = 0 asynchronously; no queued write appears afterwards.
- Write 0x99 to 0x000, then 0x47 to 0x001, GPU idle, vblank = 0 -> vram_we high on the two cycles after the pushes, same order; a GPU read of 0x001 then returns 0x47 one cycle after gpu_rd_ready.
- gpu_rd_req held high continuously, one write queued -> gpu_rd_ready drops for exactly one cycle after STARVE_LIMIT ungranted cycles (8); write committed; FIFO empty.
- Push 5 writes back-to-back with gpu_rd_req high and STARVE_LIMIT = 8 -> fifo_full after 4; 5th dropped; overflow = 1; overflow_clr pulse -> 0; a set coinciding with overflow_clr leaves overflow = 1.
- vblank = 1, gpu_rd_req high, FIFO holds 2 entries -> two consecutive write grants first, then gpu_rd_ready = 1.
- Push while full in the same cycle a pop occurs -> push accepted, fifo_level stays 4, overflow stays 0, FIFO order preserved across pointer wrap.
